// File: rtl/l2_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 memory-side signals around l2_arbiter.
// slave is the arbiter's view; master is the view of the caches and L2 around it.
interface l2_arbiter_if;
  logic         icache_pmem_read;
  logic [15:0]  icache_pmem_address;
  logic [127:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [15:0]  dcache_pmem_address;
  logic [127:0] dcache_pmem_wdata;
  logic [127:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         l2_mem_read;
  logic         l2_mem_write;
  logic [15:0]  l2_mem_address;
  logic [127:0] l2_mem_wdata;
  logic [127:0] l2_mem_rdata;
  logic         l2_mem_resp;

  modport master (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output l2_mem_rdata, l2_mem_resp,
    input  icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
    input  l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );

  modport slave (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  l2_mem_rdata, l2_mem_resp,
    output icache_pmem_rdata, icache_pmem_resp, dcache_pmem_rdata, dcache_pmem_resp,
    output l2_mem_read, l2_mem_write, l2_mem_address, l2_mem_wdata
  );
endinterface

// File: rtl/l2_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single-ported L2,
// alternating priority on ties and holding a latched request until L2 responds.
//   state   | meaning
//   IDLE    | no transaction; L2 request lines low, requesters sampled
//   SERVE_I | latched I-cache read outstanding at L2
//   SERVE_D | latched D-cache read or write-back outstanding at L2
module l2_arbiter (
  input logic          clk,
  input logic          reset,
  l2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        r_state;
  logic          r_prio;
  logic [15:0]   r_addr;
  logic [127:0]  r_wdata;
  logic          r_l2_read;
  logic          r_l2_write;

  logic          w_i_pend;
  logic          w_d_pend;
  logic          w_grant_d;

  assign w_i_pend  = bus.icache_pmem_read;
  assign w_d_pend  = bus.dcache_pmem_read | bus.dcache_pmem_write;
  assign w_grant_d = w_d_pend & (~w_i_pend | r_prio);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_l2_read  <= 1'b0;
      r_l2_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state    <= SERVE_D;
            r_addr     <= bus.dcache_pmem_address;
            r_wdata    <= bus.dcache_pmem_wdata;
            // a simultaneous read+write from the D-cache is taken as the write-back
            r_l2_write <= bus.dcache_pmem_write;
            r_l2_read  <= ~bus.dcache_pmem_write;
          end else if (w_i_pend) begin
            r_state    <= SERVE_I;
            r_addr     <= bus.icache_pmem_address;
            r_wdata    <= '0;
            r_l2_write <= 1'b0;
            r_l2_read  <= 1'b1;
          end
        end
        SERVE_I: begin
          if (bus.l2_mem_resp) begin
            r_state    <= IDLE;
            r_prio     <= 1'b1;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
          end
        end
        SERVE_D: begin
          if (bus.l2_mem_resp) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_l2_read  <= 1'b0;
          r_l2_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.l2_mem_read    = r_l2_read;
  assign bus.l2_mem_write   = r_l2_write;
  assign bus.l2_mem_address = r_addr;
  assign bus.l2_mem_wdata   = r_wdata;

  // reset wins over a same-cycle L2 response, so no completion pulse escapes
  assign bus.icache_pmem_resp  = (r_state == SERVE_I) & bus.l2_mem_resp & ~reset;
  assign bus.dcache_pmem_resp  = (r_state == SERVE_D) & bus.l2_mem_resp & ~reset;
  assign bus.icache_pmem_rdata = bus.l2_mem_rdata;
  assign bus.dcache_pmem_rdata = bus.l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios followed by random
// transactions, all checked against a transaction-level priority model.
module tb_l2_arbiter;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic m_prio;

  l2_arbiter_if bus ();

  l2_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lines(input string tag, input logic rd, input logic wr);
    chk({tag, ".l2_read"}, 128'(bus.l2_mem_read), 128'(rd));
    chk({tag, ".l2_write"}, 128'(bus.l2_mem_write), 128'(wr));
  endtask

  // One arbitration round: present requests in IDLE, then play the L2 side.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [15:0] ia, input logic [15:0] da,
                         input logic [127:0] dwd, input logic [127:0] rd,
                         input int dly, input bit perturb, input bit abort);
    logic ip, dp, wd, ew;
    logic [15:0] ea;
    bus.icache_pmem_read    = ir;
    bus.icache_pmem_address = ia;
    bus.dcache_pmem_read    = dr;
    bus.dcache_pmem_write   = dw;
    bus.dcache_pmem_address = da;
    bus.dcache_pmem_wdata   = dwd;
    tick();
    ip = ir;
    dp = dr | dw;
    if (!ip && !dp) begin
      chk_lines("idle_nogrant", 1'b0, 1'b0);
      bus.l2_mem_resp  = 1'b1;
      bus.l2_mem_rdata = rd;
      #1;
      chk("idle_spur.i_resp", 128'(bus.icache_pmem_resp), 128'(0));
      chk("idle_spur.d_resp", 128'(bus.dcache_pmem_resp), 128'(0));
      tick();
      bus.l2_mem_resp = 1'b0;
      chk_lines("idle_spur_after", 1'b0, 1'b0);
      return;
    end
    wd = dp && (!ip || m_prio);
    ew = wd && dw;
    ea = wd ? da : ia;
    chk_lines("grant", !ew, ew);
    chk("grant.addr", 128'(bus.l2_mem_address), 128'(ea));
    if (wd) chk("grant.wdata", bus.l2_mem_wdata, dwd);
    for (int k = 0; k < dly; k++) begin
      if (perturb) begin
        bus.icache_pmem_read    = 1'($urandom_range(0, 1));
        bus.icache_pmem_address = 16'($urandom);
        bus.dcache_pmem_read    = 1'($urandom_range(0, 1));
        bus.dcache_pmem_write   = 1'($urandom_range(0, 1));
        bus.dcache_pmem_address = 16'($urandom);
        bus.dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      chk_lines("hold", !ew, ew);
      chk("hold.addr", 128'(bus.l2_mem_address), 128'(ea));
      if (wd) chk("hold.wdata", bus.l2_mem_wdata, dwd);
      chk("hold.i_resp", 128'(bus.icache_pmem_resp), 128'(0));
      chk("hold.d_resp", 128'(bus.dcache_pmem_resp), 128'(0));
    end
    bus.l2_mem_rdata = rd;
    bus.l2_mem_resp  = 1'b1;
    if (abort) begin
      reset = 1'b1;
      #1;
      chk("abort.i_resp", 128'(bus.icache_pmem_resp), 128'(0));
      chk("abort.d_resp", 128'(bus.dcache_pmem_resp), 128'(0));
      tick();
      reset = 1'b0;
      bus.l2_mem_resp = 1'b0;
      m_prio = 1'b0;
      chk_lines("abort_after", 1'b0, 1'b0);
      return;
    end
    #1;
    chk("resp.i_resp", 128'(bus.icache_pmem_resp), 128'(!wd));
    chk("resp.d_resp", 128'(bus.dcache_pmem_resp), 128'(wd));
    chk("resp.i_rdata", bus.icache_pmem_rdata, rd);
    chk("resp.d_rdata", bus.dcache_pmem_rdata, rd);
    tick();
    bus.l2_mem_resp = 1'b0;
    m_prio = !wd;
    chk_lines("after_resp", 1'b0, 1'b0);
    chk("after.i_resp", 128'(bus.icache_pmem_resp), 128'(0));
    chk("after.d_resp", 128'(bus.dcache_pmem_resp), 128'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus.icache_pmem_read    = 1'b0;
    bus.icache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_wdata   = '0;
    bus.l2_mem_rdata        = '0;
    bus.l2_mem_resp         = 1'b0;
    m_prio = 1'b0;
    tick();
    tick();
    chk_lines("reset", 1'b0, 1'b0);
    chk("reset.addr", 128'(bus.l2_mem_address), 128'(0));
    chk("reset.i_resp", 128'(bus.icache_pmem_resp), 128'(0));
    chk("reset.d_resp", 128'(bus.dcache_pmem_resp), 128'(0));
    reset = 1'b0;
    tick();
    chk_lines("post_reset", 1'b0, 1'b0);

    // I-only read, L2 answering three cycles after the request
    run_txn(1, 0, 0, 16'h1230, 16'h0, '0, {32{4'hA}}, 2, 0, 0);

    // tie after reset: I first, then the D write-back
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_prio = 1'b0;
    run_txn(1, 0, 1, 16'h0100, 16'h0200, {4{32'hDEAD_BEEF}}, {4{32'h1111_2222}}, 1, 0, 0);
    run_txn(0, 0, 1, 16'h0100, 16'h0200, {4{32'hDEAD_BEEF}}, {4{32'h3333_4444}}, 1, 0, 0);

    // four back-to-back ties: grants alternate I, D, I, D
    for (int n = 0; n < 4; n++)
      run_txn(1, 1, 0, 16'h0A00 + 16'(n), 16'h0B00 + 16'(n), '0, {4{$urandom}}, 1, 0, 0);

    // D read with its address moved while outstanding
    run_txn(0, 1, 0, 16'h0, 16'h0300, '0, {4{32'h5555_6666}}, 3, 0, 0);
    bus.dcache_pmem_read = 1'b1;
    run_txn(0, 1, 0, 16'h0, 16'h0300, '0, {4{32'h7777_8888}}, 3, 1, 0);

    // read+write together latches as a write
    run_txn(0, 1, 1, 16'h0, 16'h0440, {4{32'hCAFE_F00D}}, '0, 1, 0, 0);

    // reset during SERVE_I with a same-cycle L2 response, then a tie must go to I
    run_txn(1, 0, 0, 16'h0E00, 16'h0, '0, {4{32'h9999_0000}}, 1, 0, 1);
    run_txn(1, 1, 0, 16'h0E10, 16'h0E20, '0, {4{32'h0F0F_0F0F}}, 0, 0, 0);

    // idle with a stray L2 response
    run_txn(0, 0, 0, 16'h0, 16'h0, '0, {4{32'h1234_5678}}, 0, 0, 0);

    for (int n = 0; n < 150; n++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom), {4{$urandom}}, {4{$urandom}},
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- icache_pmem_read  input  1  I-cache line-fill request.
- icache_pmem_address  input  16 (lc3b_word)  I-cache line address.
- icache_pmem_rdata  output  128 (lc3b_cacheline)  fill data to I-cache.
- icache_pmem_resp  output  1  I-cache completion pulse.
- dcache_pmem_read  input  1  D-cache line-fill request.
- dcache_pmem_write  input  1  D-cache write-back request.
- dcache_pmem_address  input  16  D-cache line address.
- dcache_pmem_wdata  input  128  D-cache write-back data.
- dcache_pmem_rdata  output  128  fill data to D-cache.
- dcache_pmem_resp  output  1  D-cache completion pulse.
- l2_mem_read, l2_mem_write  output  1 each  request to L2 (L2 acts only when exactly one is high).
- l2_mem_address  output  16  address to L2.
- l2_mem_wdata  output  128  write data to L2.
- l2_mem_rdata  input  128  read data from L2.
- l2_mem_resp  input  1  L2 completion pulse.
REQ-002 Parameters: none.

Function
REQ-003 FSM states SHALL be IDLE, SERVE_I, SERVE_D, with a registered state.
REQ-004 A 1-bit priority register prio SHALL be kept: 0 means I wins a tie, 1 means D wins a tie.
REQ-005 In IDLE, I is pending when icache_pmem_read=1; D is pending when dcache_pmem_read or dcache_pmem_write=1.
REQ-006 In IDLE with only one side pending, that side SHALL be granted; with both pending, the prio-selected side SHALL be granted.
REQ-007 On grant, the arbiter SHALL do all of the following at the same clock edge:
- latch the winner's address, wdata and op (read/write);
- move to SERVE_I or SERVE_D.
REQ-008 Latency: a request sampled in IDLE at edge N SHALL drive l2_mem_read/l2_mem_write from cycle N+1. The L2-side outputs SHALL come only from latched registers, never combinationally from requester inputs.
REQ-009 In SERVE_x, L2 request lines SHALL be driven as follows:
- I grant: l2_mem_read=1, l2_mem_write=0.
- D grant: exactly one of l2_mem_read/l2_mem_write high, per the latched op.
REQ-010 If dcache_pmem_read and dcache_pmem_write are both high at grant, the op SHALL be latched as write.
REQ-011 In SERVE_x with l2_mem_resp=1, the arbiter SHALL, in that same cycle:
- assert the granted side's *_pmem_resp combinationally;
- drive that side's *_pmem_rdata = l2_mem_rdata.
At the following edge it SHALL return to IDLE and set prio toward the other side (served I -> prio=1; served D -> prio=0).
REQ-012 The non-granted side's resp SHALL stay 0 throughout. Both *_pmem_rdata outputs SHALL pass l2_mem_rdata continuously.
REQ-013 At least one IDLE cycle SHALL separate consecutive L2 transactions. L2 request lines SHALL be 0 in IDLE.
REQ-014 If the granted requester drops its request mid-transaction, the latched L2 request SHALL still be held until l2_mem_resp, and the resp pulse SHALL still be issued.
REQ-015 Requester input changes during SERVE_x SHALL NOT alter l2_mem_address, l2_mem_wdata or the op.
REQ-016 l2_mem_resp arriving in IDLE SHALL be ignored: no requester resp, no state change.

Reset
REQ-017 While reset=1 at an edge, the block SHALL set state=IDLE, prio=0, and latched address/wdata/op=0.
REQ-018 During and after reset, l2_mem_read, l2_mem_write, icache_pmem_resp and dcache_pmem_resp SHALL be 0 until a new grant occurs.
REQ-019 Reset mid-transaction SHALL abandon the transaction without any resp pulse. Reset SHALL take precedence over l2_mem_resp in the same cycle.

Verification
REQ-020 I-only read:
- stimulus: icache_pmem_read=1, address 0x1230; L2 resp 3 cycles after its request with rdata 0xAAAA...;
- response: l2_mem_read=1 from the next cycle, l2_mem_address=0x1230; icache_pmem_resp pulses one cycle carrying 0xAAAA...; dcache_pmem_resp stays 0.
REQ-021 Simultaneous requests after reset:
- stimulus: I read 0x0100 and D write 0x0200 both asserted;
- response: I served first; one IDLE cycle; then l2_mem_write=1 with address 0x0200 and the D wdata.
REQ-022 Round-robin:
- stimulus: both sides continuously requesting for 4 transactions;
- response: grant order I, D, I, D.
REQ-023 Input stability:
- stimulus: D changes its address from 0x0300 to 0x0400 while in SERVE_D;
- response: l2_mem_address stays 0x0300 until resp.
REQ-024 Reset mid-operation:
- stimulus: reset during SERVE_I, with l2_mem_resp=1 in the same cycle;
- response: no icache_pmem_resp; next cycle state IDLE, L2 request lines 0, prio=0.
